// File: rtl/output_drain_pkg.sv
// output_drain_pkg: geometry, FSM state type and lane-slice helper shared by
// the output BRAM drain and its line buffer.
package output_drain_pkg;
    localparam int DW = 16;
    localparam int NUM_BRAMS = 16;
    localparam int O_ADDR_W = 10;
    localparam int LANE_W = $clog2(NUM_BRAMS);

    typedef enum logic [1:0] {IDLE, FILL, SEND, DONE} state_t;

    function automatic logic [DW-1:0] lane_word(input logic [NUM_BRAMS*DW-1:0] row, input logic [LANE_W-1:0] lane);
        return row[lane*DW +: DW];
    endfunction
endpackage

// File: rtl/drain_line_buffer.sv
// drain_line_buffer: ping-pong pair of row registers; one row streams out
// lane by lane while the other is filled with the prefetched next row.
module drain_line_buffer
    import output_drain_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cap_i,
    input  logic                    swap_i,
    input  logic                    clr_i,
    input  logic [LANE_W-1:0]       lane_i,
    input  logic [NUM_BRAMS*DW-1:0] row_i,
    output logic [DW-1:0]           word_o,
    output logic                    cur_vld_o
);
    logic [NUM_BRAMS*DW-1:0] buf0_q, buf1_q;
    logic sel_q, cur_vld_q, nxt_vld_q;

    // sel_q names the current row; captures always land in the other one, so
    // a capture together with a swap loads the current row directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_q    <= '0;
            buf1_q    <= '0;
            sel_q     <= 1'b0;
            cur_vld_q <= 1'b0;
            nxt_vld_q <= 1'b0;
        end else if (clr_i) begin
            cur_vld_q <= 1'b0;
            nxt_vld_q <= 1'b0;
        end else begin
            if (cap_i && sel_q) buf0_q <= row_i;
            if (cap_i && !sel_q) buf1_q <= row_i;
            if (swap_i) begin
                sel_q     <= !sel_q;
                cur_vld_q <= nxt_vld_q || cap_i;
                nxt_vld_q <= 1'b0;
            end else if (cap_i) begin
                nxt_vld_q <= 1'b1;
            end
        end
    end

    assign word_o    = lane_word(sel_q ? buf1_q : buf0_q, lane_i);
    assign cur_vld_o = cur_vld_q;
endmodule

// File: rtl/output_bram_drain.sv
// output_bram_drain: reads output BRAM rows and serialises their lanes into a
// gapless valid/ready word stream, prefetching the next row during each row.
module output_bram_drain
    import output_drain_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [O_ADDR_W-1:0]           base_addr,
    input  logic [O_ADDR_W:0]             num_rows,
    input  logic                          abort,
    output logic                          ext_read_mode,
    output logic [NUM_BRAMS*O_ADDR_W-1:0] ext_read_addr_flat,
    input  logic [NUM_BRAMS*DW-1:0]       bram_read_data_flat,
    output logic [DW-1:0]                 m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic [LANE_W-1:0]             m_lane,
    output logic                          busy,
    output logic                          done
);
    localparam logic [O_ADDR_W:0] ONE_ROW = (O_ADDR_W+1)'(1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_BRAMS - 1);

    state_t state_q, state_d;
    logic [O_ADDR_W-1:0] addr_q, addr_d;
    logic [O_ADDR_W:0] rows_q, rows_d;
    logic [LANE_W-1:0] lane_q, lane_d, lat_q, lat_d;
    logic pend_q, pend_d, zdone_q, zdone_d;
    logic cap, swap, clr, row_start, xfer, end_row, cur_vld;
    logic [DW-1:0] word;

    drain_line_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_i     (cap),
        .swap_i    (swap),
        .clr_i     (clr),
        .lane_i    (lane_q),
        .row_i     (bram_read_data_flat),
        .word_o    (word),
        .cur_vld_o (cur_vld)
    );

    assign busy               = state_q == FILL || state_q == SEND;
    assign ext_read_mode      = busy;
    assign ext_read_addr_flat = {NUM_BRAMS{addr_q}};
    assign m_valid            = state_q == SEND && cur_vld;
    assign m_data             = m_valid ? word : '0;
    assign m_lane             = lane_q;
    assign m_last             = m_valid && lane_q == LAST_LANE && rows_q == ONE_ROW;
    assign done               = state_q == DONE || zdone_q;
    assign xfer               = m_valid && m_ready;
    assign end_row            = xfer && lane_q == LAST_LANE;

    // rows_q counts rows still to be streamed, including the one in flight
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rows_d    = rows_q;
        lane_d    = lane_q;
        lat_d     = lat_q;
        pend_d    = pend_q;
        zdone_d   = 1'b0;
        cap       = 1'b0;
        swap      = 1'b0;
        clr       = 1'b0;
        row_start = 1'b0;
        case (state_q)
            IDLE: if (start && !abort) begin
                if (num_rows == '0) begin
                    zdone_d = 1'b1;
                end else begin
                    state_d = FILL;
                    addr_d  = base_addr;
                    rows_d  = num_rows;
                    lat_d   = '0;
                    pend_d  = 1'b1;
                end
            end
            FILL, SEND: if (abort) begin
                state_d = IDLE;
                clr     = 1'b1;
                rows_d  = '0;
                lane_d  = '0;
                pend_d  = 1'b0;
            end else begin
                if (pend_q) begin
                    lat_d = lat_q + LANE_W'(1);
                    if (lat_q == LANE_W'(RD_LAT)) begin
                        cap    = 1'b1;
                        pend_d = 1'b0;
                    end
                end
                if (state_q == FILL) begin
                    swap      = cap;
                    row_start = cap;
                    state_d   = cap ? SEND : FILL;
                end else if (end_row) begin
                    lane_d = '0;
                    if (rows_q == ONE_ROW) begin
                        state_d = DONE;
                        clr     = 1'b1;
                        rows_d  = '0;
                    end else begin
                        swap      = 1'b1;
                        rows_d    = rows_q - ONE_ROW;
                        row_start = 1'b1;
                    end
                end else if (xfer) begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a new row just became current: fetch its successor if one remains
        if (row_start && rows_d > ONE_ROW) begin
            addr_d = addr_q + O_ADDR_W'(1);
            pend_d = 1'b1;
            lat_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rows_q  <= '0;
            lane_q  <= '0;
            lat_q   <= '0;
            pend_q  <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rows_q  <= rows_d;
            lane_q  <= lane_d;
            lat_q   <= lat_d;
            pend_q  <= pend_d;
            zdone_q <= zdone_d;
        end
    end
endmodule

// File: tb/tb_output_bram_drain.sv
// tb_output_bram_drain: randomized drain jobs checked every cycle against a
// queue-based model of the expected beat stream, plus literal spot checks.
module tb_output_bram_drain;
    import output_drain_pkg::*;
    localparam int RDL = 1;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, m_ready = 1'b1;
    logic [O_ADDR_W-1:0] base_addr = '0;
    logic [O_ADDR_W:0] num_rows = '0;
    logic ext_read_mode, m_valid, m_last, busy, done;
    logic [NUM_BRAMS*O_ADDR_W-1:0] ext_read_addr_flat;
    logic [NUM_BRAMS*DW-1:0] rd_q = '0;
    logic [DW-1:0] m_data;
    logic [LANE_W-1:0] m_lane;

    typedef struct {logic [DW-1:0] d; logic [LANE_W-1:0] l; logic last;} beat_t;
    beat_t q[$];
    logic [DW-1:0] obs[$];
    logic [O_ADDR_W-1:0] addr_log[$];
    int total = 0, bad = 0, since = 0, done_cnt = 0, first_valid = -1;
    bit active = 0, done_exp = 0, rnd_rdy = 0, exp_v, xf, rep_ok;
    logic [DW-1:0] salt = '0;
    logic [O_ADDR_W-1:0] a0;
    beat_t bt;

    output_bram_drain #(.RD_LAT(RDL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .abort(abort), .ext_read_mode(ext_read_mode), .ext_read_addr_flat(ext_read_addr_flat),
        .bram_read_data_flat(rd_q), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .m_lane(m_lane), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_BRAMS*DW-1:0] mk_row(input int a, input logic [DW-1:0] s);
        logic [NUM_BRAMS*DW-1:0] r;
        for (int i = 0; i < NUM_BRAMS; i++) r[i*DW +: DW] = DW'(a*NUM_BRAMS + i) ^ s;
        return r;
    endfunction

    always @(posedge clk) rd_q <= mk_row(int'(ext_read_addr_flat[O_ADDR_W-1:0]), salt);
    always @(posedge clk) #1 m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // compare this cycle's outputs, then advance the model to the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
            done_exp = 0;
            q.delete();
        end else begin
            exp_v = active && since >= RDL + 1;
            a0 = ext_read_addr_flat[O_ADDR_W-1:0];
            rep_ok = 1;
            for (int i = 1; i < NUM_BRAMS; i++) if (ext_read_addr_flat[i*O_ADDR_W +: O_ADDR_W] != a0) rep_ok = 0;
            chk("busy", busy, active);
            chk("ext_read_mode", ext_read_mode, active);
            chk("m_valid", m_valid, exp_v);
            chk("done", done, done_exp);
            chk("addr_replicated", rep_ok, 1);
            if (exp_v) begin
                if (first_valid < 0) first_valid = since;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_queue act=valid exp=no_more_beats");
                end else begin
                    chk("m_data", m_data, q[0].d);
                    chk("m_lane", m_lane, q[0].l);
                    chk("m_last", m_last, q[0].last);
                end
            end
            if (ext_read_mode && (addr_log.size() == 0 || addr_log[$] != a0)) addr_log.push_back(a0);
            if (done) done_cnt++;
            xf = exp_v && m_ready && !abort && q.size() > 0;
            done_exp = 0;
            if (!active) begin
                if (start && !abort) begin
                    if (num_rows == 0) done_exp = 1;
                    else begin
                        active = 1;
                        since = 0;
                        first_valid = -1;
                        for (int r = 0; r < int'(num_rows); r++)
                            for (int i = 0; i < NUM_BRAMS; i++) begin
                                bt.d = DW'(((int'(base_addr) + r) % (1 << O_ADDR_W)) * NUM_BRAMS + i) ^ salt;
                                bt.l = LANE_W'(i);
                                bt.last = (r == int'(num_rows) - 1) && (i == NUM_BRAMS - 1);
                                q.push_back(bt);
                            end
                    end
                end
            end else if (abort) begin
                active = 0;
                q.delete();
            end else begin
                if (xf) begin
                    obs.push_back(q[0].d);
                    if (q[0].last) begin
                        active = 0;
                        done_exp = 1;
                    end
                    void'(q.pop_front());
                end
                since++;
            end
        end
    end

    task automatic go(input int b, input int n, input logic [DW-1:0] s);
        @(posedge clk);
        #1;
        salt = s;
        base_addr = O_ADDR_W'(b);
        num_rows = (O_ADDR_W+1)'(n);
        obs.delete();
        addr_log.delete();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((active || done_exp) && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 2000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout act=busy exp=idle", nm);
        end
    endtask

    task automatic wait_beats(input string nm, input int n);
        int k = 0;
        while (obs.size() < n && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 2000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout act=%0d exp=%0d", nm, obs.size(), n);
        end
    endtask

    initial begin
        int d0, errs, n;
        logic [DW-1:0] s;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {m_valid, busy, done, ext_read_mode, m_last}, 0);
        chk("rst_data", {m_data, 4'(m_lane)}, 0);
        chk("rst_addr", ext_read_addr_flat == '0, 1);
        rst_n = 1'b1;

        go(0, 2, 0);
        wait_idle("basic");
        chk("basic_beats", obs.size(), 32);
        chk("basic_first", obs[0], 0);
        chk("basic_last", obs[31], 31);
        chk("basic_latency", first_valid, 2);
        chk("basic_done_cnt", done_cnt, 1);

        rnd_rdy = 1;
        go(0, 2, 0);
        wait_idle("backpressure");
        errs = 0;
        for (int i = 0; i < obs.size(); i++) if (obs[i] != DW'(i)) errs++;
        chk("bp_seq_errs", errs, 0);
        chk("bp_beats", obs.size(), 32);

        rnd_rdy = 0;
        go(1023, 2, 0);
        wait_idle("wrap");
        chk("wrap_addr_n", addr_log.size(), 2);
        chk("wrap_addr0", addr_log[0], 1023);
        chk("wrap_addr1", addr_log[1], 0);
        chk("wrap_data0", obs[0], 16368);
        chk("wrap_data16", obs[16], 0);

        d0 = done_cnt;
        go(5, 0, 0);
        wait_idle("zero");
        chk("zero_done", done_cnt - d0, 1);
        chk("zero_beats", obs.size(), 0);

        d0 = done_cnt;
        go(100, 4, DW'($urandom));
        wait_beats("abort", 4);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_valid", m_valid, 0);
        chk("abort_mode", ext_read_mode, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_beats", obs.size(), 4);
        rnd_rdy = 1;
        s = DW'($urandom);
        go(200, 2, s);
        wait_idle("replay");
        chk("replay_beats", obs.size(), 32);
        chk("replay_first", obs[0], DW'(200*16) ^ s);

        rnd_rdy = 0;
        d0 = done_cnt;
        s = DW'($urandom);
        go(300, 3, s);
        repeat (10) @(posedge clk);
        #1;
        base_addr = O_ADDR_W'(600);
        num_rows = (O_ADDR_W+1)'(1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("ignore");
        chk("ign_beats", obs.size(), 48);
        chk("ign_done", done_cnt - d0, 1);
        chk("ign_lastword", obs[47], DW'(302*16 + 15) ^ s);

        go(400, 4, DW'($urandom));
        wait_beats("rst_mid", 20);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {m_valid, busy, done, ext_read_mode, m_last}, 0);
        chk("arst_data", {m_data, 4'(m_lane)}, 0);
        chk("arst_addr", ext_read_addr_flat == '0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int j = 0; j < 5; j++) begin
            rnd_rdy = (j != 0);
            n = $urandom_range(1, 5);
            go($urandom_range(0, 1023), n, DW'($urandom));
            wait_idle("random");
            chk("rand_beats", obs.size(), n * NUM_BRAMS);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
